uart_tx_core: RTL and testbench
===============================

// Module: uart_tx_core
// PURPOSE
//  8N1 UART transmitter with an integrated baud-tick generator.
//  Accepts a byte on a one-cycle start strobe and serialises it LSB first on tx_data.
//  Sits between the system bus and the board TX pin; one instance per UART channel.
//  The tick is also exported for debug and for sharing with sibling logic.
// PARAMETERS
//  SYS_CLK     100_000_000        system clock frequency, Hz
//  BAUD        9600               line rate, bit/s
//  BAUD_COUNT  SYS_CLK/BAUD       clocks per bit; must be >= 2; counter width $clog2(BAUD_COUNT)
// PORTS
//  clk            in   1  system clock; all logic on rising edge
//  rst            in   1  synchronous, active-high reset
//  start_trigger  in   1  start request; sampled on rising clk; one-cycle pulse suffices
//  i_data         in   8  byte to send; sampled on the accepting edge only
//  tx_data        out  1  serial line; idle high; registered
//  tx_busy        out  1  high while a frame is in progress (state != IDLE); registered
//  tx_done        out  1  one-cycle pulse at frame end; registered
//  baud_tick      out  1  one-cycle pulse every BAUD_COUNT clocks while busy
// BEHAVIOUR
//  Reset: state=IDLE, tx_data=1, tx_busy=0, tx_done=0, baud_tick=0, baud counter=0, bit index=0.
//  Reset mid-frame aborts the frame; tx_data=1 from the next edge.
//  Baud generator:
//   - counter held at 0 in IDLE; cleared on the accepting edge.
//   - increments each clk while busy; baud_tick=1 when count==BAUD_COUNT-1; the counter then wraps to 0.
//  FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
//   - IDLE: start_trigger=1 at edge k latches i_data into a shift register, enters START,
//     sets tx_data=0 and tx_busy=1 after edge k.
//   - START: on baud_tick go to DATA, tx_data=data[0], bit index=0.
//   - DATA: on each baud_tick, shift out the next bit.
//     After bit 7's tick go to STOP with tx_data=1.
//   - STOP: on baud_tick go to IDLE; tx_busy=0 and tx_done=1 for exactly one cycle.
//  Timing: every bit, including start and stop, lasts exactly BAUD_COUNT clocks.
//   - Start bit covers cycles k+1..k+BAUD_COUNT.
//   - A frame is 10*BAUD_COUNT clocks; tx_done is high in cycle k+10*BAUD_COUNT+1.
//  start_trigger is ignored while tx_busy=1, and changes to i_data during a frame have no effect.
//  A trigger in the tx_done cycle (state already IDLE) is accepted.
//   - Back-to-back frames therefore have zero idle-bit gap beyond the stop bit.
//  A trigger held high continuously restarts a new frame each time IDLE is reached.
//  Bit order LSB first; no parity; one stop bit.
// TESTING
//  Params SYS_CLK=100, BAUD=10 (BAUD_COUNT=10) for all cases.
//  1. rst=1 for 2 cycles -> tx_data=1, tx_busy=0, tx_done=0, baud_tick=0.
//  2. i_data=0x55, one-cycle start_trigger -> tx_data = 0,1,0,1,0,1,0,1,0,1.
//     Each level is held 10 clocks, then tx_done pulses once and tx_busy falls.
//  3. i_data=0x80, trigger; change i_data to 0x00 mid-frame ->
//     bits = 0 | 0000000 1 | 1; i_data change has no effect.
//  4. Pulse trigger again 30 clocks into a frame -> ignored; the frame completes unchanged;
//     exactly one tx_done.
//  5. Trigger with 0xA3 in the tx_done cycle of the previous frame ->
//     new start bit begins the next cycle; no extra idle bit.
//  6. Assert rst 45 clocks into a 0xFF frame -> tx_data=1, tx_busy=0 next edge;
//     a fresh trigger afterwards sends a clean frame.

Source files
------------

// File: rtl/uart_tx_core_if.sv
// Bus-side signal bundle for one UART transmit channel.
// The master drives the byte and start request; the slave is the transmitter core.
interface uart_tx_core_if;
  logic       start_trigger;
  logic [7:0] i_data;
  logic       tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       baud_tick;

  modport master (
    output start_trigger,
    output i_data,
    input  tx_data,
    input  tx_busy,
    input  tx_done,
    input  baud_tick
  );

  modport slave (
    input  start_trigger,
    input  i_data,
    output tx_data,
    output tx_busy,
    output tx_done,
    output baud_tick
  );
endinterface

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter with an integrated baud-tick generator.
// A one-cycle start strobe latches a byte, which is sent LSB first framed by
// one low start bit and one high stop bit, each bit lasting BAUD_COUNT clocks.
module uart_tx_core #(
  parameter int SYS_CLK    = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int BAUD_COUNT = SYS_CLK / BAUD
) (
  input logic           clk,
  input logic           rst,
  uart_tx_core_if.slave bus
);

  localparam int                 CNT_W    = (BAUD_COUNT > 1) ? $clog2(BAUD_COUNT) : 1;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BAUD_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_baudCnt;
  logic [2:0]       r_bitIdx;
  logic [7:0]       r_shift;
  logic             r_txData;
  logic             r_txBusy;
  logic             r_txDone;

  logic             w_tick;
  logic             w_accept;
  logic             w_txDataNext;
  logic             w_txBusyNext;
  logic             w_txDoneNext;
  logic [2:0]       w_bitIdxNext;
  logic [7:0]       w_shiftNext;

  assign w_tick   = (r_state != IDLE) && (r_baudCnt == LAST_CNT);
  assign w_accept = (r_state == IDLE) && bus.start_trigger;

  // Baud counter: parked at zero when idle, free-runs and wraps every bit period while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baudCnt <= '0;
    end else if (r_state == IDLE || r_baudCnt == LAST_CNT) begin
      r_baudCnt <= '0;
    end else begin
      r_baudCnt <= r_baudCnt + CNT_W'(1);
    end
  end

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: every bit boundary is marked by the baud tick.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_nextState = START;
      START:   if (w_tick) w_nextState = DATA;
      DATA:    if (w_tick && r_bitIdx == 3'd7) w_nextState = STOP;
      STOP:    if (w_tick) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output logic: computes the next line level, shift register and status flags.
  always_comb begin
    w_txDataNext = r_txData;
    w_txBusyNext = (w_nextState != IDLE);
    w_txDoneNext = 1'b0;
    w_bitIdxNext = r_bitIdx;
    w_shiftNext  = r_shift;
    unique case (r_state)
      IDLE: begin
        w_txDataNext = 1'b1;
        if (w_accept) begin
          w_txDataNext = 1'b0;
          w_shiftNext  = bus.i_data;
          w_bitIdxNext = 3'd0;
        end
      end
      START: begin
        if (w_tick) begin
          w_txDataNext = r_shift[0];
          w_shiftNext  = {1'b0, r_shift[7:1]};
          w_bitIdxNext = 3'd0;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bitIdx == 3'd7) begin
            w_txDataNext = 1'b1;
          end else begin
            w_txDataNext = r_shift[0];
            w_shiftNext  = {1'b0, r_shift[7:1]};
            w_bitIdxNext = r_bitIdx + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          w_txDataNext = 1'b1;
          w_txDoneNext = 1'b1;
        end
      end
      default: w_txDataNext = 1'b1;
    endcase
  end

  // Output and datapath registers so the pin and status flags are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txData <= 1'b1;
      r_txBusy <= 1'b0;
      r_txDone <= 1'b0;
      r_bitIdx <= 3'd0;
      r_shift  <= 8'h00;
    end else begin
      r_txData <= w_txDataNext;
      r_txBusy <= w_txBusyNext;
      r_txDone <= w_txDoneNext;
      r_bitIdx <= w_bitIdxNext;
      r_shift  <= w_shiftNext;
    end
  end

  assign bus.tx_data   = r_txData;
  assign bus.tx_busy   = r_txBusy;
  assign bus.tx_done   = r_txDone;
  assign bus.baud_tick = w_tick;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed testbench for uart_tx_core with BAUD_COUNT = 10.
// Time inside a frame is counted as t = 1..100 where t=1 is the first cycle after
// the accepting edge; the done pulse lands in t = 101.
module tb_uart_tx_core;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  uart_tx_core_if bus ();

  uart_tx_core #(
    .SYS_CLK(100),
    .BAUD   (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected to finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected line level at frame cycle t (1..100) for byte d.
  function automatic logic expLevel(input logic [7:0] d, input int t);
    int bitPos;
    bitPos = (t - 1) / 10;
    if (bitPos == 0) return 1'b0;
    if (bitPos == 9) return 1'b1;
    return d[bitPos-1];
  endfunction

  // Advance to just after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents a byte with a one-cycle start strobe; returns in frame cycle t=1.
  task automatic pulseStart(input logic [7:0] d);
    bus.i_data        = d;
    bus.start_trigger = 1'b1;
    stepCycle();
    bus.start_trigger = 1'b0;
  endtask

  task automatic test_reset();
    rst               = 1'b1;
    bus.start_trigger = 1'b0;
    bus.i_data        = 8'h00;
    stepCycle();
    stepCycle();
    testsRun++;
    if (bus.tx_data !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0 || bus.baud_tick !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset: tx_data=%b busy=%b done=%b tick=%b, expected 1 0 0 0",
               bus.tx_data, bus.tx_busy, bus.tx_done, bus.baud_tick);
    end
    rst = 1'b0;
    stepCycle();
    testsRun++;
    if (bus.tx_data !== 1'b1 || bus.tx_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL idle_after_reset: tx_data=%b busy=%b, expected 1 0", bus.tx_data, bus.tx_busy);
    end
  endtask

  task automatic test_frame_55();
    pulseStart(8'h55);
    for (int t = 1; t <= 100; t++) begin
      testsRun++;
      if (bus.tx_data !== expLevel(8'h55, t) || bus.tx_busy !== 1'b1 || bus.tx_done !== 1'b0 ||
          bus.baud_tick !== ((t % 10) == 0)) begin
        testsFailed++;
        $display("[TB] FAIL frame55 t=%0d: tx_data=%b busy=%b done=%b tick=%b, expected tx_data=%b busy=1 done=0 tick=%b",
                 t, bus.tx_data, bus.tx_busy, bus.tx_done, bus.baud_tick, expLevel(8'h55, t), ((t % 10) == 0));
      end
      stepCycle();
    end
    testsRun++;
    if (bus.tx_done !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_data !== 1'b1 || bus.baud_tick !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL frame55_done: done=%b busy=%b tx_data=%b tick=%b, expected 1 0 1 0",
               bus.tx_done, bus.tx_busy, bus.tx_data, bus.baud_tick);
    end
    stepCycle();
    testsRun++;
    if (bus.tx_done !== 1'b0 || bus.tx_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL frame55_done_once: done=%b busy=%b, expected 0 0", bus.tx_done, bus.tx_busy);
    end
  endtask

  task automatic test_data_change();
    pulseStart(8'h80);
    for (int t = 1; t <= 100; t++) begin
      if (t == 30) bus.i_data = 8'h00;
      testsRun++;
      if (bus.tx_data !== expLevel(8'h80, t) || bus.tx_busy !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL frame80 t=%0d: tx_data=%b busy=%b, expected tx_data=%b busy=1",
                 t, bus.tx_data, bus.tx_busy, expLevel(8'h80, t));
      end
      stepCycle();
    end
    testsRun++;
    if (bus.tx_done !== 1'b1 || bus.tx_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL frame80_done: done=%b busy=%b, expected 1 0", bus.tx_done, bus.tx_busy);
    end
    stepCycle();
  endtask

  task automatic test_ignore_trigger();
    int doneCount;
    doneCount = 0;
    pulseStart(8'h3C);
    for (int t = 1; t <= 100; t++) begin
      if (t == 30) begin
        bus.i_data        = 8'hFF;
        bus.start_trigger = 1'b1;
      end
      if (t == 31) bus.start_trigger = 1'b0;
      testsRun++;
      if (bus.tx_data !== expLevel(8'h3C, t) || bus.tx_busy !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL frame3C t=%0d: tx_data=%b busy=%b, expected tx_data=%b busy=1",
                 t, bus.tx_data, bus.tx_busy, expLevel(8'h3C, t));
      end
      if (bus.tx_done === 1'b1) doneCount++;
      stepCycle();
    end
    for (int t = 101; t <= 115; t++) begin
      if (bus.tx_done === 1'b1) doneCount++;
      testsRun++;
      if (bus.tx_busy !== 1'b0 || bus.tx_data !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL frame3C_idle t=%0d: busy=%b tx_data=%b, expected 0 1", t, bus.tx_busy, bus.tx_data);
      end
      stepCycle();
    end
    testsRun++;
    if (doneCount != 1) begin
      testsFailed++;
      $display("[TB] FAIL frame3C_done_count: saw %0d done pulses, expected 1", doneCount);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    pulseStart(8'h5A);
    for (int f = 0; f < 2; f++) begin
      d = (f == 0) ? 8'h5A : 8'hA3;
      for (int t = 1; t <= 100; t++) begin
        testsRun++;
        if (bus.tx_data !== expLevel(d, t) || bus.tx_busy !== 1'b1 || bus.tx_done !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL b2b frame%0d t=%0d: tx_data=%b busy=%b done=%b, expected tx_data=%b busy=1 done=0",
                   f, t, bus.tx_data, bus.tx_busy, bus.tx_done, expLevel(d, t));
        end
        stepCycle();
      end
      testsRun++;
      if (bus.tx_done !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_data !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL b2b_done frame%0d: done=%b busy=%b tx_data=%b, expected 1 0 1",
                 f, bus.tx_done, bus.tx_busy, bus.tx_data);
      end
      if (f == 0) begin
        bus.i_data        = 8'hA3;
        bus.start_trigger = 1'b1;
      end
      stepCycle();
      bus.start_trigger = 1'b0;
    end
    testsRun++;
    if (bus.tx_done !== 1'b0 || bus.tx_busy !== 1'b0 || bus.tx_data !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_end: done=%b busy=%b tx_data=%b, expected 0 0 1",
               bus.tx_done, bus.tx_busy, bus.tx_data);
    end
  endtask

  task automatic test_reset_midframe();
    pulseStart(8'hFF);
    for (int t = 1; t < 45; t++) begin
      testsRun++;
      if (bus.tx_data !== expLevel(8'hFF, t) || bus.tx_busy !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL frameFF t=%0d: tx_data=%b busy=%b, expected tx_data=%b busy=1",
                 t, bus.tx_data, bus.tx_busy, expLevel(8'hFF, t));
      end
      stepCycle();
    end
    rst = 1'b1;
    stepCycle();
    testsRun++;
    if (bus.tx_data !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0 || bus.baud_tick !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midframe_reset: tx_data=%b busy=%b done=%b tick=%b, expected 1 0 0 0",
               bus.tx_data, bus.tx_busy, bus.tx_done, bus.baud_tick);
    end
    rst = 1'b0;
    stepCycle();
    stepCycle();
    testsRun++;
    if (bus.tx_data !== 1'b1 || bus.tx_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_idle: tx_data=%b busy=%b, expected 1 0", bus.tx_data, bus.tx_busy);
    end
    pulseStart(8'h96);
    for (int t = 1; t <= 100; t++) begin
      testsRun++;
      if (bus.tx_data !== expLevel(8'h96, t) || bus.tx_busy !== 1'b1 ||
          bus.baud_tick !== ((t % 10) == 0)) begin
        testsFailed++;
        $display("[TB] FAIL frame96 t=%0d: tx_data=%b busy=%b tick=%b, expected tx_data=%b busy=1 tick=%b",
                 t, bus.tx_data, bus.tx_busy, bus.baud_tick, expLevel(8'h96, t), ((t % 10) == 0));
      end
      stepCycle();
    end
    testsRun++;
    if (bus.tx_done !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_data !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL frame96_done: done=%b busy=%b tx_data=%b, expected 1 0 1",
               bus.tx_done, bus.tx_busy, bus.tx_data);
    end
    stepCycle();
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_frame_55();
    test_data_change();
    test_ignore_trigger();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
